// File: rtl/next_pc_unit_pkg.sv
// Shared definitions for the next-PC / instruction-fetch unit:
// fetch FSM state encoding, default reset PC and sequential increment.
package next_pc_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_INC_DEFAULT   = 32'd4;

    // Branch targets are forced onto a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_unit_inst_skid_buf.sv
// One-entry buffer holding a fetched instruction and its PC while decode stalls.
module inst_skid_buf (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] data_in,
    input  logic [31:0] pc_in,
    output logic        valid,
    output logic [31:0] data,
    output logic [31:0] pc
);

    logic        valid_r;
    logic [31:0] data_r;
    logic [31:0] pc_r;

    // Buffer storage; clear wins over load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_r <= 1'b0;
            data_r  <= 32'h0000_0000;
            pc_r    <= 32'h0000_0000;
        end else if (clear) begin
            valid_r <= 1'b0;
            data_r  <= 32'h0000_0000;
            pc_r    <= 32'h0000_0000;
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= data_in;
            pc_r    <= pc_in;
        end else begin
            valid_r <= valid_r;
            data_r  <= data_r;
            pc_r    <= pc_r;
        end
    end

    assign valid = valid_r;
    assign data  = data_r;
    assign pc    = pc_r;

endmodule

// File: rtl/next_pc_unit.sv
// Next-PC generator with single-outstanding instruction fetch, stall buffer,
// execute redirects and dropping of responses made stale by a redirect.
module next_pc_unit
    import next_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] PC_INC   = PC_INC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] current_pc,
    output logic [31:0] next_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic        misalign_err
);

    state_e      state_r;
    logic        kill_r;
    logic        redir_s, accept_s, resp_s, outstanding_s;
    logic        deliver_s, capture_s, hold_s, consume_s, buf_clear_s;
    logic        buf_valid_s;
    logic [31:0] buf_data_s, buf_pc_s;

    assign redir_s       = redirect_valid && (state_r != ST_IDLE);
    assign accept_s      = (state_r == ST_REQ) && imem_ready;
    assign resp_s        = (state_r == ST_WAIT) && imem_rvalid;
    assign outstanding_s = ((state_r == ST_WAIT) && !imem_rvalid) || accept_s;
    assign deliver_s     = resp_s && !kill_r && !stall && !redir_s;
    assign capture_s     = resp_s && !kill_r && stall && !redir_s;
    assign hold_s        = (state_r == ST_HOLD) && buf_valid_s && !redir_s;
    assign consume_s     = hold_s && !stall;
    assign buf_clear_s   = redir_s || consume_s;

    inst_skid_buf u_skid (
        .clk     (clk),
        .reset   (reset),
        .load    (capture_s),
        .clear   (buf_clear_s),
        .data_in (imem_rdata),
        .pc_in   (current_pc),
        .valid   (buf_valid_s),
        .data    (buf_data_s),
        .pc      (buf_pc_s)
    );

    // Fetch FSM and kill flag; a redirect overrides every other transition.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            kill_r  <= 1'b0;
        end else if (redir_s) begin
            state_r <= outstanding_s ? ST_WAIT : ST_REQ;
            kill_r  <= outstanding_s;
        end else begin
            case (state_r)
                ST_IDLE: state_r <= ST_REQ;
                ST_REQ:  state_r <= imem_ready ? ST_WAIT : ST_REQ;
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        kill_r  <= 1'b0;
                        state_r <= (!kill_r && stall) ? ST_HOLD : ST_REQ;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_HOLD: state_r <= stall ? ST_HOLD : ST_REQ;
                default: begin
                    state_r <= ST_IDLE;
                    kill_r  <= 1'b0;
                end
            endcase
        end
    end

    // Next-PC mux: the PC holds unless an instruction is handed to decode.
    always_comb begin
        next_pc = current_pc;
        if (state_r == ST_IDLE) begin
            next_pc = RESET_PC;
        end else if (redir_s) begin
            next_pc = align_word(redirect_target);
        end else if (deliver_s || consume_s) begin
            next_pc = current_pc + PC_INC;
        end else begin
            next_pc = current_pc;
        end
    end

    // Decode-side outputs come either straight from memory or from the buffer.
    always_comb begin
        inst_valid = 1'b0;
        inst_out   = 32'h0000_0000;
        inst_pc    = 32'h0000_0000;
        if (deliver_s) begin
            inst_valid = 1'b1;
            inst_out   = imem_rdata;
            inst_pc    = current_pc;
        end else if (hold_s) begin
            inst_valid = 1'b1;
            inst_out   = buf_data_s;
            inst_pc    = buf_pc_s;
        end else begin
            inst_valid = 1'b0;
        end
    end

    assign imem_req     = (state_r == ST_REQ);
    assign imem_addr    = imem_req ? current_pc : 32'h0000_0000;
    assign misalign_err = redir_s && (redirect_target[1:0] != 2'b00);

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed, table-driven bench for next_pc_unit with a modelled PC register.
module tb_next_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] current_pc;
    logic [31:0] next_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready, imem_rvalid, stall, redirect_valid;
    logic [31:0] imem_rdata, redirect_target;
    logic        inst_valid, misalign_err;
    logic [31:0] inst_out, inst_pc;

    int n_cmp = 0;
    int n_bad = 0;

    next_pc_unit dut (
        .clk             (clk),
        .reset           (reset),
        .current_pc      (current_pc),
        .next_pc         (next_pc),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .inst_valid      (inst_valid),
        .inst_out        (inst_out),
        .inst_pc         (inst_pc),
        .misalign_err    (misalign_err)
    );

    always #5 clk = ~clk;

    // PC register: latches next_pc on every rising edge.
    always @(posedge clk) current_pc <= next_pc;

    typedef struct {
        logic        rdy, rv;
        logic [31:0] rdata;
        logic        stall, rdv;
        logic [31:0] rdt;
        logic [31:0] npc;
        logic        req, iv;
        logic [31:0] inst, ipc;
        logic        mis;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rdy, rv, input logic [31:0] rdata,
                       input logic st, rdv, input logic [31:0] rdt, npc,
                       input logic req, iv, input logic [31:0] inst, ipc,
                       input logic mis);
        vec_t v;
        v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.stall = st; v.rdv = rdv;
        v.rdt = rdt; v.npc = npc; v.req = req; v.iv = iv; v.inst = inst;
        v.ipc = ipc; v.mis = mis;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [31:0] npc,
                            input logic req, iv, input logic [31:0] inst, ipc,
                            input logic mis);
        chk({tag, " next_pc"}, next_pc, npc);
        chk({tag, " imem_req"}, {31'd0, imem_req}, {31'd0, req});
        chk({tag, " inst_valid"}, {31'd0, inst_valid}, {31'd0, iv});
        chk({tag, " inst_out"}, inst_out, inst);
        chk({tag, " inst_pc"}, inst_pc, ipc);
        chk({tag, " misalign_err"}, {31'd0, misalign_err}, {31'd0, mis});
        if (req) chk({tag, " imem_addr"}, imem_addr, current_pc);
    endtask

    task automatic drive(input logic rdy, rv, input logic [31:0] rdata,
                         input logic st, rdv, input logic [31:0] rdt);
        imem_ready = rdy; imem_rvalid = rv; imem_rdata = rdata;
        stall = st; redirect_valid = rdv; redirect_target = rdt;
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        //      rdy  rv    rdata         st   rdv   rdt            npc            req  iv    inst          ipc            mis
        add(1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1'b0); // IDLE
        add(1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0,        32'h0,        1'b0);
        add(1'b0, 1'b1, 32'hA000_0000, 1'b0, 1'b0, 32'h0,       32'h4,        1'b0, 1'b1, 32'hA000_0000, 32'h0,       1'b0);
        add(1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h4,        1'b1, 1'b0, 32'h0,        32'h0,        1'b0);
        add(1'b0, 1'b1, 32'hA000_0001, 1'b0, 1'b0, 32'h0,       32'h8,        1'b0, 1'b1, 32'hA000_0001, 32'h4,       1'b0);
        add(1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h8,        1'b1, 1'b0, 32'h0,        32'h0,        1'b0);
        add(1'b0, 1'b1, 32'hA000_0002, 1'b0, 1'b0, 32'h0,       32'hC,        1'b0, 1'b1, 32'hA000_0002, 32'h8,       1'b0);
        add(1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'hC,        1'b1, 1'b0, 32'h0,        32'h0,        1'b0);
        add(1'b0, 1'b1, 32'hA000_0003, 1'b0, 1'b0, 32'h0,       32'h10,       1'b0, 1'b1, 32'hA000_0003, 32'hC,       1'b0);
        // memory not ready, then a response delay, then a 3-cycle stall
        add(1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h10,       1'b1, 1'b0, 32'h0,        32'h0,        1'b0);
        add(1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h10,       1'b1, 1'b0, 32'h0,        32'h0,        1'b0);
        add(1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h10,       1'b0, 1'b0, 32'h0,        32'h0,        1'b0);
        add(1'b0, 1'b1, 32'hA000_0004, 1'b1, 1'b0, 32'h0,       32'h10,       1'b0, 1'b0, 32'h0,        32'h0,        1'b0);
        add(1'b0, 1'b0, 32'hFFFF_0000, 1'b1, 1'b0, 32'h0,       32'h10,       1'b0, 1'b1, 32'hA000_0004, 32'h10,      1'b0);
        add(1'b0, 1'b0, 32'hFFFF_0000, 1'b1, 1'b0, 32'h0,       32'h10,       1'b0, 1'b1, 32'hA000_0004, 32'h10,      1'b0);
        add(1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h14,       1'b0, 1'b1, 32'hA000_0004, 32'h10,      1'b0);
        // redirect while waiting: stale response dropped
        add(1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h14,       1'b1, 1'b0, 32'h0,        32'h0,        1'b0);
        add(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h200,      32'h200,      1'b0, 1'b0, 32'h0,        32'h0,        1'b0);
        add(1'b0, 1'b1, 32'hBAD0_0014, 1'b0, 1'b0, 32'h0,       32'h200,      1'b0, 1'b0, 32'h0,        32'h0,        1'b0);
        add(1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h200,      1'b1, 1'b0, 32'h0,        32'h0,        1'b0);
        add(1'b0, 1'b1, 32'hA000_0005, 1'b0, 1'b0, 32'h0,       32'h204,      1'b0, 1'b1, 32'hA000_0005, 32'h200,     1'b0);
        // misaligned redirect in REQ without acceptance
        add(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h103,      32'h100,      1'b1, 1'b0, 32'h0,        32'h0,        1'b1);
        add(1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h100,      1'b1, 1'b0, 32'h0,        32'h0,        1'b0);
        add(1'b0, 1'b1, 32'hA000_0006, 1'b0, 1'b0, 32'h0,       32'h104,      1'b0, 1'b1, 32'hA000_0006, 32'h100,     1'b0);
        // redirect in REQ with acceptance: request killed, then address wrap
        add(1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0,      32'h0,        1'b0);
        add(1'b0, 1'b1, 32'hBAD0_0104, 1'b0, 1'b0, 32'h0,       32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0,       32'h0,        1'b0);
        add(1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0,       32'h0,        1'b0);
        add(1'b0, 1'b1, 32'hA000_0007, 1'b0, 1'b0, 32'h0,       32'h0,        1'b0, 1'b1, 32'hA000_0007, 32'hFFFF_FFFC, 1'b0);
        // redirect coincident with rvalid: dropped, no kill left behind
        add(1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0,        32'h0,        1'b0);
        add(1'b0, 1'b1, 32'hBAD0_0000, 1'b0, 1'b1, 32'h40,      32'h40,       1'b0, 1'b0, 32'h0,        32'h0,        1'b0);
        add(1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h40,       1'b1, 1'b0, 32'h0,        32'h0,        1'b0);
        add(1'b0, 1'b1, 32'hA000_0009, 1'b0, 1'b0, 32'h0,       32'h44,       1'b0, 1'b1, 32'hA000_0009, 32'h40,      1'b0);
        // redirect while holding: buffer flushed
        add(1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h44,       1'b1, 1'b0, 32'h0,        32'h0,        1'b0);
        add(1'b0, 1'b1, 32'hA000_000A, 1'b1, 1'b0, 32'h0,       32'h44,       1'b0, 1'b0, 32'h0,        32'h0,        1'b0);
        add(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h80,       32'h80,       1'b0, 1'b0, 32'h0,        32'h0,        1'b0);
        add(1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h80,       1'b1, 1'b0, 32'h0,        32'h0,        1'b0);
        add(1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h80,       1'b1, 1'b0, 32'h0,        32'h0,        1'b0);

        // Reset state, with a redirect that must be ignored in IDLE.
        repeat (3) @(negedge clk);
        drive(1'b1, 1'b1, 32'h1234_5678, 1'b0, 1'b1, 32'h103);
        #1;
        chk_outs("reset", 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rdy, vecs[i].rv, vecs[i].rdata, vecs[i].stall,
                  vecs[i].rdv, vecs[i].rdt);
            #1;
            chk_outs($sformatf("vec%0d", i), vecs[i].npc, vecs[i].req,
                     vecs[i].iv, vecs[i].inst, vecs[i].ipc, vecs[i].mis);
            @(negedge clk);
        end

        // Asynchronous reset in the middle of a delivering WAIT cycle.
        drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        #1;
        chk_outs("pre_async", 32'h84, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h80, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk_outs("async_rst", 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk_outs("post_idle", 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        #1;
        chk_outs("post_req", 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        chk_outs("post_req2", 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b1, 32'hC000_0000, 1'b0, 1'b0, 32'h0);
        #1;
        chk_outs("post_fetch", 32'h4, 1'b0, 1'b1, 32'hC000_0000, 32'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
